uart_bytes_rx: RTL and testbench
================================

Name: uart_bytes_rx

Overview:
Multi-byte UART receiver. It is the downstream counterpart of uart_bytes_tx and the receive side of the UART link. It deserialises BYTES consecutive 8N1 characters from uart_rxd into one packed word and pulses uart_bytes_done once per complete frame. Framing errors and stalled partial frames are discarded so the receiver always re-aligns to the next frame.

Parameters:
BYTES, 5, number of bytes per received frame.
BPS, 230400, baud rate.
CLK_FRE, 50_000_000, sys_clk frequency in Hz.
TIMEOUT_BITS, 20, idle bit-times after which a partial frame is discarded.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rst  input  1  synchronous reset, active-high.
uart_rxd  input  1  asynchronous UART receive line; idles high.
uart_bytes_data  output  BYTES*8  last complete frame; valid when uart_bytes_done is high, held until the next frame completes.
uart_bytes_done  output  1  one-cycle pulse when a full frame has been received.
uart_bytes_err  output  1  one-cycle pulse on a framing error (stop bit sampled low).

Behaviour:
- Clock and reset: one clock (sys_clk). sys_rst is synchronous and active-high.
- Bit timing: BIT_CNT = CLK_FRE/BPS, integer division (217 at defaults). Mid-bit sample point is BIT_CNT/2 (108).
- Reset values: uart_bytes_data = 0, uart_bytes_done = 0, uart_bytes_err = 0. Synchroniser flops reset to 1. Byte index = 0. Timeout counter = 0. Byte FSM in IDLE.
- Input path: uart_rxd passes through a 2-FF synchroniser plus one history flop for falling-edge detection. All decisions use the synchronised value.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised falling edge; baud counter cleared.
  - START: at the mid-bit point, line low -> DATA; line high -> IDLE (glitch rejected, nothing reported).
  - DATA: samples 8 bits at successive mid-bit points, LSB first, then -> STOP.
  - STOP: at mid-stop, line high -> byte_valid pulse; line low -> byte_err pulse. Either way -> IDLE at that cycle so the next start edge is caught early.
- Frame assembly: the first byte on the wire maps to bits [BYTES*8-1 -: 8] (MSB byte first, matching uart_bytes_tx). Bytes are shifted into an internal shift register.
  - On byte_valid with index == BYTES-1: uart_bytes_data <= {shift register, new byte}, uart_bytes_done = 1 on the next cycle, index <= 0.
  - Otherwise index increments.
- Latency: uart_bytes_done rises 1 cycle after the mid-stop sample of the last byte. uart_bytes_data updates in that same cycle, atomically, and is never partially updated.
- Framing error: uart_bytes_err pulses 1 cycle after the mid-stop sample. Index resets to 0, the partial frame is discarded, and uart_bytes_data is unchanged.
- Timeout: while index != 0 and the byte FSM is IDLE, count clocks. At TIMEOUT_BITS*BIT_CNT clocks, index <= 0 silently with no err. The counter clears on any START entry.
- Simultaneous events: if byte_valid and timeout expiry fall in the same cycle, byte_valid wins and the timer clears. done and err can never assert together.
- Reset mid-operation: everything returns to reset values and any in-flight byte or frame is dropped. The first falling edge after sys_rst deasserts starts a fresh frame.
- Back-to-back frames with zero idle time between stop and start are supported.

Decomposition:
- No shared package is needed. BIT_CNT, HALF_CNT and the timeout limit are localparams derived from the parameters. FSM state encoding is local to uart_byte_rx.
- One sub-module, uart_byte_rx (params BPS, CLK_FRE): synchroniser, byte FSM and baud counter. Outputs byte_data[7:0], byte_valid, byte_err.
- uart_bytes_rx contains only frame assembly and the timeout logic.

Test Plan:
- Clean frame: 5 back-to-back bytes 0x12,0x34,0x56,0x78,0x9A at 4340 ns/bit -> exactly one done pulse, data = 40'h123456789A, err never high.
- Glitch rejection: uart_rxd low for 50 clocks while idle -> no done, no err; a following frame 0x0102030405 is received correctly.
- Framing error: stop bit of byte 3 forced low -> one err pulse, no done, data unchanged. Then frame 0xAABBCCDDEE -> done, data = 40'hAABBCCDDEE.
- Timeout: send 2 bytes (0xFF,0xFF), idle 25 bit-times, then frame 0x0102030405 -> single done with data = 40'h0102030405, no mixing.
- Reset mid-frame: assert sys_rst for 2 clocks during byte 2 -> data/done/err = 0. The next full frame 0x1122334455 is received correctly.
- Loopback: uart_bytes_tx (sys_rst_n = ~sys_rst) drives uart_rxd with 3 random 40-bit words -> each done's data equals the transmitted word; 3 done pulses total.

Source files
------------

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - single 8N1 character receiver with input synchroniser
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst     synchronous reset, active-high
//   uart_rxd    asynchronous serial input, idles high
//   byte_data   last received character (LSB arrived first)
//   byte_valid  one-cycle pulse at mid-stop when the stop bit is high
//   byte_err    one-cycle pulse at mid-stop when the stop bit is low
//   busy        high whenever a character is in progress (FSM not IDLE)
module uart_byte_rx #(
  parameter int BPS     = 230400,
  parameter int CLK_FRE = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       busy
);
  localparam int BIT_CNT  = CLK_FRE / BPS;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta, rx_sync, rx_hist;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          cnt_clr, sample;
  logic          fall;

  assign fall = rx_hist & ~rx_sync;

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    sample     = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fall) state_d = START;
      end
      START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (baud_cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        // One full bit after mid-start lands on the middle of each data bit.
        if (baud_cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          sample  = 1'b1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a zero-gap next start edge is not missed.
        if (baud_cnt == BIT_LAST) begin
          cnt_clr    = 1'b1;
          state_d    = IDLE;
          byte_valid = rx_sync;
          byte_err   = ~rx_sync;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_hist  <= 1'b1;
      state_q  <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      rx_meta  <= uart_rxd;
      rx_sync  <= rx_meta;
      rx_hist  <= rx_sync;
      state_q  <= state_d;
      baud_cnt <= cnt_clr ? '0 : baud_cnt + CW'(1);
      if (state_q == START) bit_idx <= '0;
      else if (sample)      bit_idx <= bit_idx + 3'd1;
      if (sample) shift_q <= {rx_sync, shift_q[7:1]};
    end
  end

  assign byte_data = shift_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: rtl/uart_bytes_rx.sv
// rtl/uart_bytes_rx.sv - multi-byte UART frame receiver with stall timeout
//
// Ports:
//   sys_clk          system clock, rising edge
//   sys_rst          synchronous reset, active-high
//   uart_rxd         asynchronous serial input, idles high
//   uart_bytes_data  last complete frame, first byte on the wire in the MSBs
//   uart_bytes_done  one-cycle pulse when a full frame has been received
//   uart_bytes_err   one-cycle pulse on a framing error
module uart_bytes_rx #(
  parameter int BYTES        = 5,
  parameter int BPS          = 230400,
  parameter int CLK_FRE      = 50_000_000,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               uart_rxd,
  output logic [BYTES*8-1:0] uart_bytes_data,
  output logic               uart_bytes_done,
  output logic               uart_bytes_err
);
  localparam int BIT_CNT  = CLK_FRE / BPS;
  localparam int TO_LIMIT = TIMEOUT_BITS * BIT_CNT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam int IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SW       = (BYTES - 1) * 8;
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_LIMIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_err, busy;
  logic [IW-1:0] idx;
  logic [SW-1:0] shreg;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  uart_byte_rx #(
    .BPS     (BPS),
    .CLK_FRE (CLK_FRE)
  ) u_byte_rx (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .uart_rxd   (uart_rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .busy       (busy)
  );

  // Only a stalled partial frame (receiver idle mid-frame) can time out;
  // byte_valid only occurs while busy, so it always wins over expiry.
  assign timeout_hit = (idx != '0) && !busy && (to_cnt == TO_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      uart_bytes_data <= '0;
      uart_bytes_done <= 1'b0;
      uart_bytes_err  <= 1'b0;
      idx             <= '0;
      shreg           <= '0;
      to_cnt          <= '0;
    end else begin
      uart_bytes_done <= 1'b0;
      uart_bytes_err  <= 1'b0;

      if (byte_valid) begin
        if (idx == LAST_IDX) begin
          uart_bytes_data <= {shreg, byte_data};
          uart_bytes_done <= 1'b1;
          idx             <= '0;
        end else begin
          // Stale bytes from a discarded frame are fully shifted out
          // before the next completion, so no clear is needed.
          shreg <= (shreg << 8) | SW'(byte_data);
          idx   <= idx + IW'(1);
        end
      end else if (byte_err) begin
        uart_bytes_err <= 1'b1;
        idx            <= '0;
      end else if (timeout_hit) begin
        idx <= '0;
      end

      if (idx == '0 || busy || timeout_hit) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_uart_bytes_rx.sv
// tb/tb_uart_bytes_rx.sv - scoreboard bench for uart_bytes_rx
module tb_uart_bytes_rx;
  localparam int BYTES        = 5;
  localparam int BPS          = 230400;
  localparam int CLK_FRE      = 50_000_000;
  localparam int TIMEOUT_BITS = 20;
  localparam int BIT          = CLK_FRE / BPS;

  logic              sys_clk  = 1'b0;
  logic              sys_rst  = 1'b1;
  logic              uart_rxd = 1'b1;
  logic [BYTES*8-1:0] uart_bytes_data;
  logic              uart_bytes_done;
  logic              uart_bytes_err;

  uart_bytes_rx #(
    .BYTES        (BYTES),
    .BPS          (BPS),
    .CLK_FRE      (CLK_FRE),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .uart_rxd        (uart_rxd),
    .uart_bytes_data (uart_bytes_data),
    .uart_bytes_done (uart_bytes_done),
    .uart_bytes_err  (uart_bytes_err)
  );

  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int err_seen = 0;
  int exp_done = 0;
  int done_seen = 0;
  logic [BYTES*8-1:0] exp_q[$];
  logic [7:0]         model_bytes[$];
  logic [BYTES*8-1:0] last_word = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a frame or error.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (uart_bytes_done && uart_bytes_err)
        check("done_err_exclusive", 64'd1, 64'd0);
      if (uart_bytes_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(uart_bytes_data), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          last_word = exp_q.pop_front();
          check("frame_data", 64'(uart_bytes_data), 64'(last_word));
        end
      end
      if (uart_bytes_err) begin
        err_seen++;
        check("data_held_on_err", 64'(uart_bytes_data), 64'(last_word));
      end
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(negedge sys_clk);
  endtask

  // Reference model: bytes accumulate until BYTES good ones are collected;
  // a bad stop bit or a long idle discards them.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [BYTES*8-1:0] w;
    if (stop_ok) begin
      model_bytes.push_back(b);
      if (model_bytes.size() == BYTES) begin
        w = '0;
        foreach (model_bytes[i]) w = (w << 8) | (BYTES*8)'(model_bytes[i]);
        exp_q.push_back(w);
        exp_done++;
        model_bytes.delete();
      end
    end else begin
      exp_err++;
      model_bytes.delete();
    end
    uart_rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_bits(1);
    end
    uart_rxd = stop_ok;
    wait_bits(1);
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int bits);
    if (bits > TIMEOUT_BITS) model_bytes.delete();
    uart_rxd = 1'b1;
    wait_bits(bits);
  endtask

  task automatic send_frame(input logic [BYTES*8-1:0] w);
    for (int i = 0; i < BYTES; i++) send_byte(w[BYTES*8-1-8*i -: 8], 1'b1);
  endtask

  initial begin
    logic [BYTES*8-1:0] rw;

    sys_rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("reset_data", 64'(uart_bytes_data), 64'd0);
    check("reset_done", 64'(uart_bytes_done), 64'd0);
    check("reset_err",  64'(uart_bytes_err),  64'd0);
    sys_rst = 1'b0;
    idle(2);

    // Clean back-to-back frame
    send_frame(40'h123456789A);
    idle(3);

    // Glitch on an idle line must be ignored
    uart_rxd = 1'b0;
    repeat (50) @(negedge sys_clk);
    uart_rxd = 1'b1;
    idle(2);
    send_frame(40'h0102030405);
    idle(2);

    // Framing error on the third byte
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(2);
    send_frame(40'hAABBCCDDEE);
    idle(2);

    // Stalled partial frame is discarded by the timeout
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(25);
    send_frame(40'h0102030405);
    idle(2);

    // Reset in the middle of byte 2
    send_byte(8'h5A, 1'b1);
    uart_rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = i[0];
      wait_bits(1);
    end
    uart_rxd = 1'b1;
    sys_rst  = 1'b1;
    model_bytes.delete();
    repeat (2) @(negedge sys_clk);
    last_word = '0;
    check("midrst_data", 64'(uart_bytes_data), 64'd0);
    check("midrst_done", 64'(uart_bytes_done), 64'd0);
    check("midrst_err",  64'(uart_bytes_err),  64'd0);
    sys_rst = 1'b0;
    idle(2);
    send_frame(40'h1122334455);
    idle(2);

    // Random frames, zero idle between them
    for (int k = 0; k < 3; k++) begin
      rw = {8'($urandom), 32'($urandom)};
      send_frame(rw);
    end
    idle(4);

    check("pending_frames", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(exp_done));
    check("err_count",  64'(err_seen),  64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
